// File: rtl/rec2pol_seq.sv
// Upstream sequencer for the rec2pol CORDIC core: formats integer (X,Y) pairs to 16.16,
// runs the core's start/enable protocol for a fixed latency and presents the captured result.
module rec2pol_seq #(
  parameter int IN_W    = 16,
  parameter int FRAC_W  = 16,
  parameter int LATENCY = 32,
  parameter int CNT_W   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_x,
  input  logic [IN_W-1:0]          in_y,
  output logic                     cordic_start,
  output logic                     cordic_enable,
  output logic [IN_W+FRAC_W-1:0]   cordic_x,
  output logic [IN_W+FRAC_W-1:0]   cordic_y,
  input  logic [31:0]              cordic_mod,
  input  logic [31:0]              cordic_angle,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_mod,
  output logic [31:0]              out_angle,
  output logic                     busy,
  output logic [CNT_W-1:0]         conv_cnt
);

  localparam int             CTR_W = $clog2(LATENCY + 1);
  localparam logic [CTR_W-1:0] LAST = CTR_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, HOLD} state_t;

  state_t                   r_state, w_state_nxt;
  logic [CTR_W-1:0]         r_count;
  logic                     r_zero;
  logic                     r_start, r_enable, r_valid, r_busy;
  logic                     w_start_nxt, w_enable_nxt, w_valid_nxt, w_busy_nxt;
  logic [IN_W+FRAC_W-1:0]   r_x, r_y;
  logic [31:0]              r_mod, r_angle;
  logic [CNT_W-1:0]         r_cnt;
  logic                     w_accept, w_capture, w_done;

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_capture = (r_state == RUN) && (r_count == LAST);
  assign w_done    = (r_state == HOLD) && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)  w_state_nxt = START;
      START:                  w_state_nxt = RUN;
      RUN:     if (w_capture) w_state_nxt = HOLD;
      HOLD:    if (w_done)    w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    w_start_nxt  = (w_state_nxt == START);
    w_enable_nxt = (w_state_nxt == START) || (w_state_nxt == RUN);
    w_valid_nxt  = (w_state_nxt == HOLD);
    w_busy_nxt   = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_start  <= 1'b0;
      r_enable <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_count  <= '0;
      r_zero   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_mod    <= '0;
      r_angle  <= '0;
      r_cnt    <= '0;
    end else begin
      r_start  <= w_start_nxt;
      r_enable <= w_enable_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;

      if (w_accept) begin
        r_x    <= {in_x, {FRAC_W{1'b0}}};
        r_y    <= {in_y, {FRAC_W{1'b0}}};
        r_zero <= (in_x == '0) && (in_y == '0);
      end

      if (r_state == START)    r_count <= '0;
      else if (r_state == RUN) r_count <= r_count + CTR_W'(1);

      // atan2(0,0) is undefined, so the angle is forced to zero for a zero vector.
      if (w_capture) begin
        r_mod   <= cordic_mod;
        r_angle <= r_zero ? 32'd0 : cordic_angle;
      end

      if (w_done) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready      = (r_state == IDLE);
  assign cordic_start  = r_start;
  assign cordic_enable = r_enable;
  assign cordic_x      = r_x;
  assign cordic_y      = r_y;
  assign out_valid     = r_valid;
  assign out_mod       = r_mod;
  assign out_angle     = r_angle;
  assign busy          = r_busy;
  assign conv_cnt      = r_cnt;

endmodule
